img_blit_dma: RTL and testbench
===============================

// Module: img_blit_dma
// PURPOSE
//  Hardware blitter that copies a block of pixels from image ROM (region 2) into VGA RAM (region 4).
//  Sits beside the ARM core behind the chipset decoder and shares the image-ROM read port and the
//  VGA-RAM write port with the CPU; the CPU always wins, the blitter fills idle cycles.
//  Uncontended throughput is 1 pixel/clk via a 2-entry buffer.
// PARAMETERS
//  LEN_W   16  width of the pixel-count (length) field
//  ADDR_W  32  width of the source and destination addresses
// PORTS
//  clk           in   1       system clock; all logic is on this one clock
//  reset         in   1       synchronous, active-high reset
//  start         in   1       1-cycle request; src_base, dst_base and len are sampled on it
//  src_base      in   ADDR_W  image-ROM start address
//  dst_base      in   ADDR_W  VGA-RAM start address
//  len           in   LEN_W   number of pixels to copy
//  cpu_rom_req   in   1       CPU owns the image-ROM port this cycle
//  cpu_vga_req   in   1       CPU owns the VGA-RAM write port this cycle
//  rom_req       out  1       blitter drives the ROM address this cycle (selects the mux)
//  rom_addr      out  ADDR_W  ROM read address
//  rom_rd        in   8       ROM data; valid exactly 1 clk after rom_req
//  vga_we        out  1       VGA-RAM write strobe
//  vga_addr      out  ADDR_W  VGA-RAM write address
//  vga_wd        out  8       VGA-RAM write data
//  busy          out  1       transfer in progress
//  done          out  1       1-cycle pulse at transfer completion
//  count         out  LEN_W   pixels retired (written or skipped) in the current/last transfer
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; buffer and in-flight read are discarded.
//    Reset mid-transfer aborts the transfer with no done pulse.
//  - FSM states: IDLE -> RUN on start. RUN -> DONE when retired==len. DONE -> IDLE after 1 clk.
//  - DONE: done=1 and busy=0 in that cycle. count holds its value until the next start.
//  - start is ignored unless the FSM is in IDLE.
//  - len==0: IDLE -> DONE directly. done is in cycle+1; no rom_req, no vga_we.
//  - Read issue: rom_req=1 in RUN when issued<len && !cpu_rom_req && (occupancy+inflight)<2.
//    rom_addr = src_base+issued.
//  - Read capture: rom_rd is captured into the 2-entry FIFO in the cycle after issue,
//    unconditionally. The issue rule guarantees the FIFO has space.
//  - Write: when the FIFO is non-empty && !cpu_vga_req, the head entry is popped.
//    vga_we=1, vga_addr=dst_base+retired, vga_wd=head.
//    vga_we, vga_addr and vga_wd are combinational from FIFO state.
//  - Latency, uncontended, start in cycle 0:
//    rom_req in cycles 1..len; vga_we in cycles 3..len+2; done in cycle len+3.
//  - Pixel order is strictly preserved. Each address is issued exactly once; there are no retries.
//  - Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
//  - Counters are LEN_W bits; issued and retired never exceed len.
//  - Push and pop in the same cycle with the FIFO full: legal, and occupancy is unchanged.
//  - CPU priority is absolute: cpu_*_req=1 forces the matching blitter strobe to 0 in that same cycle.
// CONFIGURATION
//  BLIT_COLORKEY_EN defined:
//   - adds input port colorkey [7:0].
//   - A head pixel equal to colorkey is popped and retired (count++, address advances) with vga_we=0.
//   - Such a pop ignores cpu_vga_req.
//  BLIT_COLORKEY_EN undefined: no colorkey port; every pixel is written.
// STRUCTURE
//  - Package blit_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} blit_state_t;
//    localparam LEN_W_DEF = 16.
//  - Sub-module blit_fifo2: 2-entry, 8-bit synchronous FIFO.
//    Ports: push, pop, din, dout, empty, full, occ[1:0].
//  - Top level holds the FSM, the issued/retired counters and the inflight flag.
// TESTING
//  1. src=0x10, dst=0x100, len=4, ROM[0x10..0x13]=A1,B2,C3,D4, no contention
//     -> rom_addr 0x10..0x13 in cycles 1-4
//     -> writes (0x100,A1)..(0x103,D4) in cycles 3-6
//     -> done in cycle 7, count=4.
//  2. Same as test 1 with cpu_vga_req=1 in cycles 3-5
//     -> no vga_we in cycles 3-5; rom_req drops when occ+inflight=2
//     -> all 4 pixels written in order by cycle 9; done in cycle 10.
//  3. len=0 -> done in cycle 1, busy never 1, no rom_req and no vga_we.
//  4. len=8; reset=1 in the cycle after the 2nd write
//     -> next cycle all outputs 0, no done pulse
//     -> a new start with len=1 completes normally with count=1.
//  5. dst=0xFFFF_FFFE, len=4, with a second start in cycle 2
//     -> writes go to FFFF_FFFE, FFFF_FFFF, 0, 1
//     -> the second start is ignored.
//  6. BLIT_COLORKEY_EN defined, colorkey=0x00, ROM=00,55,00,66
//     -> only (dst+1,55) and (dst+3,66) are written; count=4; done pulses.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and default widths for the image-ROM to VGA-RAM blitter.
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } blit_state_t;

  localparam int LEN_W_DEF  = 16;
  localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/blit_fifo2.sv
// Two-entry, 8-bit synchronous FIFO decoupling ROM reads from VGA-RAM writes.
module blit_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic [1:0] occ
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign empty   = (occ == 2'd0);
  assign full    = (occ == 2'd2);
  assign do_pop  = pop && !empty;
  // A full FIFO accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; occ alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/img_blit_dma.sv
// Blitter copying len pixels from image ROM to VGA RAM in CPU-idle cycles.
// Optional feature macro: BLIT_COLORKEY_EN (adds colorkey input; matching pixels are skipped).
module img_blit_dma
  import blit_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpu_rom_req,
  input  logic              cpu_vga_req,
`ifdef BLIT_COLORKEY_EN
  input  logic [7:0]        colorkey,
`endif
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rd,
  output logic              vga_we,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_wd,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  blit_state_t       state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  retired;
  logic [LEN_W-1:0]  retired_next;
  logic              inflight;

  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        occ;
  logic [1:0]        occ_after;
  logic [1:0]        pending;
  logic [7:0]        head;
  logic              skip;
  logic              write;
  logic              pop;
  logic              issue;

`ifdef BLIT_COLORKEY_EN
  assign skip = !fifo_empty && (head == colorkey);
`else
  assign skip = 1'b0;
`endif

  // Transparent pixels retire without touching the VGA port, so the CPU cannot stall them.
  assign write        = !fifo_empty && !skip && !cpu_vga_req;
  assign pop          = write || skip;
  assign retired_next = retired + LEN_W'(pop);

  // Space is judged after this cycle's pop so an uncontended stream sustains 1 pixel/clk.
  assign occ_after = occ - {1'b0, pop};
  assign pending   = occ_after + {1'b0, inflight};
  assign issue     = (state == RUN) && (issued != len_q) && !cpu_rom_req &&
                     (pending < 2'd2) && !(fifo_full && !pop);

  assign rom_req  = issue;
  assign rom_addr = issue ? src_q + ADDR_W'(issued) : '0;
  assign vga_we   = write;
  assign vga_addr = write ? dst_q + ADDR_W'(retired) : '0;
  assign vga_wd   = write ? head : 8'h00;
  assign count    = retired;

  blit_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (rom_rd),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .occ   (occ)
  );

  // NOTE: all state here updates with <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      inflight <= 1'b0;
      issued   <= '0;
      retired  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
    end else begin
      inflight <= issue;
      if (issue) issued  <= issued + LEN_W'(1);
      if (pop)   retired <= retired_next;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            len_q   <= len;
            issued  <= '0;
            retired <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && (retired_next == len_q)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_blit_dma.sv
// Self-checking bench for img_blit_dma: directed scenarios plus randomized contention runs.
// Build with BLIT_COLORKEY_EN defined to also exercise transparent-pixel skipping.
module tb_img_blit_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] len;
  logic        cpu_rom_req;
  logic        cpu_vga_req;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [7:0]  rom_rd;
  logic        vga_we;
  logic [31:0] vga_addr;
  logic [7:0]  vga_wd;
  logic        busy;
  logic        done;
  logic [15:0] count;
`ifdef BLIT_COLORKEY_EN
  logic [7:0]  colorkey;
`endif

  always #5 clk = ~clk;

  img_blit_dma dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .len         (len),
    .cpu_rom_req (cpu_rom_req),
    .cpu_vga_req (cpu_vga_req),
`ifdef BLIT_COLORKEY_EN
    .colorkey    (colorkey),
`endif
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .vga_we      (vga_we),
    .vga_addr    (vga_addr),
    .vga_wd      (vga_wd),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  // Image ROM model: data appears one clock after the request; garbage otherwise.
  logic [7:0] rom_mem [256];
  always @(posedge clk) rom_rd <= rom_req ? rom_mem[rom_addr[7:0]] : 8'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Per-run observation log, indexed by cycle relative to start (cycle 0).
  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc;
  int          done_cnt;
  int          busy_err;
  int          prio_err;
  logic [15:0] count_at_done;
  bit          rom_blk [256];
  bit          vga_blk [256];

  task automatic clear_contention();
    for (int c = 0; c < 256; c++) begin
      rom_blk[c] = 1'b0;
      vga_blk[c] = 1'b0;
    end
  endtask

  task automatic random_contention(input int pct);
    for (int c = 0; c < 256; c++) begin
      rom_blk[c] = ($urandom_range(0, 99) < pct);
      vga_blk[c] = ($urandom_range(0, 99) < pct);
    end
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int start2_cyc, input int abort_after_wr, input int max_cyc);
    bit exp_busy;
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc = -1; done_cnt = 0; busy_err = 0; prio_err = 0; count_at_done = '0;
    for (int c = 0; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      start       = (c == 0) || (c == start2_cyc);
      src_base    = (c == 0) ? s : $urandom;
      dst_base    = (c == 0) ? d : $urandom;
      len         = (c == 0) ? n : 16'($urandom_range(1, 9));
      cpu_rom_req = (c < 256) ? rom_blk[c] : 1'b0;
      cpu_vga_req = (c < 256) ? vga_blk[c] : 1'b0;
      #3;
      if (rom_req) begin rd_addr_q.push_back(rom_addr); rd_cyc_q.push_back(c); end
      if (vga_we) begin
        wr_addr_q.push_back(vga_addr); wr_data_q.push_back(vga_wd); wr_cyc_q.push_back(c);
      end
      if ((cpu_rom_req && rom_req) || (cpu_vga_req && vga_we)) prio_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; count_at_done = count; end
      end
      exp_busy = (n != 0) && (c >= 1) && !done;
      if (busy !== exp_busy) busy_err++;
      if (done_cyc >= 0) break;
      if (abort_after_wr > 0 && wr_addr_q.size() == abort_after_wr) break;
    end
    start = 1'b0; cpu_rom_req = 1'b0; cpu_vga_req = 1'b0;
  endtask

  // Reference: pixel i comes from src+i and lands at dst+i, in order, unless transparent.
  task automatic verify(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] n, input bit key_en, input logic [7:0] key,
                        input bit timed, input int exp_done);
    logic [31:0] e_rd[$];
    logic [31:0] e_wa[$];
    logic [7:0]  e_wd[$];
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] sa;
      logic [7:0]  px;
      sa = s + 32'(i);
      px = rom_mem[sa[7:0]];
      e_rd.push_back(sa);
      if (!(key_en && px == key)) begin
        e_wa.push_back(d + 32'(i));
        e_wd.push_back(px);
      end
    end
    check({tag, " done seen"}, 64'(done_cyc >= 0), 64'd1);
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    if (exp_done >= 0) check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, " count at done"}, 64'(count_at_done), 64'(n));
    check({tag, " busy profile errors"}, 64'(busy_err), 64'd0);
    check({tag, " cpu priority errors"}, 64'(prio_err), 64'd0);
    check({tag, " read count"}, 64'(rd_addr_q.size()), 64'(e_rd.size()));
    for (int i = 0; i < e_rd.size() && i < rd_addr_q.size(); i++) begin
      check($sformatf("%s rd_addr[%0d]", tag, i), 64'(rd_addr_q[i]), 64'(e_rd[i]));
      if (timed) check($sformatf("%s rd_cyc[%0d]", tag, i), 64'(rd_cyc_q[i]), 64'(i + 1));
    end
    check({tag, " write count"}, 64'(wr_addr_q.size()), 64'(e_wa.size()));
    for (int i = 0; i < e_wa.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), 64'(wr_addr_q[i]), 64'(e_wa[i]));
      check($sformatf("%s wr_data[%0d]", tag, i), 64'(wr_data_q[i]), 64'(e_wd[i]));
      if (timed && !key_en) check($sformatf("%s wr_cyc[%0d]", tag, i), 64'(wr_cyc_q[i]), 64'(i + 3));
    end
    @(posedge clk);
    #4;
    check({tag, " count holds"}, 64'(count), 64'(n));
    check({tag, " done single cycle"}, 64'(done), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rom_req"}, 64'(rom_req), 64'd0);
    check({tag, " rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, " vga_we"}, 64'(vga_we), 64'd0);
    check({tag, " vga_addr"}, 64'(vga_addr), 64'd0);
    check({tag, " vga_wd"}, 64'(vga_wd), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " count"}, 64'(count), 64'd0);
  endtask

  initial begin
    int          stray_done;
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] n;

    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    cpu_rom_req = 1'b0; cpu_vga_req = 1'b0;
`ifdef BLIT_COLORKEY_EN
    colorkey = 8'h00;
`endif
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    clear_contention();
    repeat (2) @(posedge clk);
    #4;
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic uncontended copy.
    rom_mem[8'h10] = 8'hA1; rom_mem[8'h11] = 8'hB2; rom_mem[8'h12] = 8'hC3; rom_mem[8'h13] = 8'hD4;
    run_xfer(32'h10, 32'h100, 16'd4, -1, 0, 40);
    verify("t1", 32'h10, 32'h100, 16'd4, 1'b0, 8'h00, 1'b1, 7);

    // CPU holds the VGA port in cycles 3-5.
    vga_blk[3] = 1'b1; vga_blk[4] = 1'b1; vga_blk[5] = 1'b1;
    run_xfer(32'h10, 32'h100, 16'd4, -1, 0, 40);
    if (wr_cyc_q.size() > 0) check("t2 last write by cycle 9", 64'(wr_cyc_q[$] <= 9), 64'd1);
    verify("t2", 32'h10, 32'h100, 16'd4, 1'b0, 8'h00, 1'b0, 10);
    clear_contention();

    // Zero-length transfer.
    run_xfer(32'h20, 32'h200, 16'd0, -1, 0, 20);
    verify("t3", 32'h20, 32'h200, 16'd0, 1'b0, 8'h00, 1'b1, 1);

    // Reset in the cycle after the second write aborts silently.
    run_xfer(32'h30, 32'h300, 16'd8, -1, 2, 40);
    check("t4 writes before abort", 64'(wr_addr_q.size()), 64'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #3 check_zero("t4 post reset");
    stray_done = 0;
    repeat (6) begin
      @(posedge clk);
      #4 if (done) stray_done++;
    end
    check("t4 no done after abort", 64'(stray_done), 64'd0);
    run_xfer(32'h50, 32'h500, 16'd1, -1, 0, 20);
    verify("t4b", 32'h50, 32'h500, 16'd1, 1'b0, 8'h00, 1'b1, 4);

    // Destination wrap-around with an ignored second start.
    run_xfer(32'h60, 32'hFFFF_FFFE, 16'd4, 2, 0, 40);
    verify("t5", 32'h60, 32'hFFFF_FFFE, 16'd4, 1'b0, 8'h00, 1'b1, 7);

    // Random lengths, addresses and contention.
    for (int k = 0; k < 6; k++) begin
      s = $urandom; d = $urandom; n = 16'($urandom_range(1, 24));
      random_contention($urandom_range(10, 60));
      run_xfer(s, d, n, -1, 0, 250);
      verify($sformatf("rnd%0d", k), s, d, n, 1'b0, 8'h00, 1'b0, -1);
    end
    clear_contention();
    for (int k = 0; k < 3; k++) begin
      s = $urandom; d = $urandom; n = 16'($urandom_range(1, 40));
      run_xfer(s, d, n, -1, 0, 100);
      verify($sformatf("free%0d", k), s, d, n, 1'b0, 8'h00, 1'b1, -1);
    end

`ifdef BLIT_COLORKEY_EN
    // Transparent pixels are retired but not written.
    colorkey = 8'h00;
    rom_mem[8'h40] = 8'h00; rom_mem[8'h41] = 8'h55; rom_mem[8'h42] = 8'h00; rom_mem[8'h43] = 8'h66;
    run_xfer(32'h40, 32'h400, 16'd4, -1, 0, 40);
    verify("t6", 32'h40, 32'h400, 16'd4, 1'b1, 8'h00, 1'b0, 7);
    for (int k = 0; k < 2; k++) begin
      colorkey = 8'($urandom);
      for (int i = 0; i < 256; i++) rom_mem[i] = ($urandom_range(0, 2) == 0) ? colorkey : 8'($urandom);
      s = $urandom; d = $urandom; n = 16'($urandom_range(1, 20));
      random_contention(40);
      run_xfer(s, d, n, -1, 0, 250);
      verify($sformatf("key%0d", k), s, d, n, 1'b1, colorkey, 1'b0, -1);
    end
    clear_contention();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
